display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Scan scheduler for the six-digit status display of the Tamagotchi FSM.
- Time-shares one 7-segment decoder across six anode lines (two 3-digit banks).
- Sequences digits with drive and dead-time phases and takes one coherent snapshot of all six stat values per frame.
- Arbitrates between normal scan, a button-selected focus page and low-stat alert blinking; feeds the BCD-to-segment decoder and the anode pins.

Parameters:
- DRIVE_CYC, 50000, clk cycles each digit is driven.
- DEAD_CYC, 500, clk cycles all anodes are off between digits (anti-ghosting).
- BLINK_FRAMES, 64, frames per blink half-period for alerted digits.
- ALERT_LVL, 1, a stat value <= ALERT_LVL raises an alert for that digit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- stat_bus  in  18  six 3-bit stats; [2:0]=food, [5:3]=sleep, [8:6]=fun, [11:9]=happy, [14:12]=health, [17:15]=aux
- btn_pulse  in  1  debounced single-cycle button pulse
- digit_val  out  4  value to the BCD decoder; 4'hF = blank code
- an  out  3  bank-0 anodes, active-low
- an1  out  3  bank-1 anodes, active-low
- frame_start  out  1  one-cycle pulse when digit 0 begins DRIVE
- alert  out  1  OR of all per-digit alert flags in the current snapshot
- page  out  3  0 = SCAN page, 1..6 = FOCUS on digit page-1

Behaviour:
- Reset (rst==0 at a posedge clk) forces the following, whether idle or mid-frame:
  - state=DEAD, idx=0, cyc=0, page=0, snapshot=0, blink_ph=0.
  - an=an1=3'b111, digit_val=4'hF, frame_start=0, alert=0.
- FSM states are DRIVE and DEAD; a cycle counter cyc runs within each state.
- DEAD:
  - All anodes are high and digit_val=4'hF.
  - After DEAD_CYC cycles, enter DRIVE.
  - If idx==0 on that transition: latch stat_bus into the snapshot, recompute alert flags, pulse frame_start for 1 cycle, and increment the frame counter.
- DRIVE:
  - Exactly one anode is low: idx 0..2 maps to an[idx], idx 3..5 maps to an1[idx-3].
  - digit_val = zero-extended snapshot[idx].
  - After DRIVE_CYC cycles, enter DEAD with idx advanced; 5 wraps to 0.
- Frame period = 6*(DRIVE_CYC+DEAD_CYC). The first DRIVE after reset starts DEAD_CYC cycles after rst is released.
- Snapshot rule: stat_bus changes mid-frame are not displayed until the next frame start.
- Alert blink:
  - blink_ph toggles every BLINK_FRAMES frames.
  - When blink_ph==1 and digit idx is alerted, digit_val=4'hF during DRIVE; the anode is still driven so timing is unchanged.
- Page arbitration:
  - btn_pulse increments page, wrapping 6 to 0.
  - The new page takes effect at the next frame_start, never mid-frame.
  - For a FOCUS page p, every DRIVE slot shows snapshot[p-1] on that slot's anode.
  - Alert blinking still applies, keyed on digit p-1.
- Simultaneous events: btn_pulse arriving in the same cycle as a frame latch is counted and applies at the following frame. Multiple pulses within one frame each increment the pending page.
- All outputs are registered; digit_val and anodes change on the same clock edge.

Optional Feature:
- Macro: DISPLAY_SCAN_DIM_EN.
- When defined:
  - Adds input port bright[2:0].
  - During DRIVE, the anode is low only while cyc[7:5] < bright. bright==0 leaves the digit fully dark; bright==7 drives it 7/8 of the time.
  - digit_val is unaffected.
- When undefined: no bright port, and the anode is low for the full DRIVE phase.

Decomposition:
- Shared package tamagotchi_disp_pkg holds:
  - BLANK_CODE=4'hF and NUM_DIGITS=6.
  - Stat slot index constants FOOD=0 … AUX=5.
  - The state encoding DRIVE/DEAD.
- One sub-module, disp_timebase: holds cyc, state and idx, and generates frame_start. The top level holds the snapshot, alert, blink and page logic.

Test Plan:
- Reset and scan (DRIVE_CYC=4, DEAD_CYC=2, stat_bus=18'o543210): release rst → an low in order 110,101,011, then an1 110,101,011; digit_val is 0,1,2,3,4,5; each digit is low for 4 cycles with 2 fully-dark cycles between; frame_start has a 36-cycle period.
- Snapshot coherency: change stat_bus to all 7s while idx=2 → digits 2..5 still show 2..5; the next frame shows 7 on all six digits.
- Alert blink (BLINK_FRAMES=2, health=0, others=5): alert=1; digit 4 shows 4'hF in frames 2,3,6,7… and shows 0 in the other frames; the other digits always show 5.
- Page: single btn_pulse mid-frame → page=1 from the next frame_start; all six slots show the food value; after six further pulses page returns to 0.
- Reset mid-DRIVE at idx=3: on the next edge an=an1=111 and digit_val=F; after release, scanning restarts at digit 0 with page=0.
- DISPLAY_SCAN_DIM_EN, bright=2, DRIVE_CYC=256: the anode is low for 64 of 256 drive cycles; bright=0 keeps all anodes high.

Source files
------------

// File: rtl/tamagotchi_disp_pkg.sv
// Shared definitions for the Tamagotchi status display: blank code, digit count,
// stat slot indices, scan state encoding and a stat-slot extraction helper.
package tamagotchi_disp_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         NUM_DIGITS = 6;

    localparam logic [2:0] FOOD   = 3'd0;
    localparam logic [2:0] SLEEP  = 3'd1;
    localparam logic [2:0] FUN    = 3'd2;
    localparam logic [2:0] HAPPY  = 3'd3;
    localparam logic [2:0] HEALTH = 3'd4;
    localparam logic [2:0] AUX    = 3'd5;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    function automatic logic [2:0] stat_at(input logic [17:0] bus, input logic [2:0] slot);
        case (slot)
            FOOD:    return bus[2:0];
            SLEEP:   return bus[5:3];
            FUN:     return bus[8:6];
            HAPPY:   return bus[11:9];
            HEALTH:  return bus[14:12];
            AUX:     return bus[17:15];
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/disp_timebase.sv
// Digit scan timebase: DRIVE/DEAD state, per-state cycle counter and digit index.
// Exposes next-state values so the top can register its outputs on the same edge.
// Optional DISPLAY_SCAN_DIM_EN adds the sub_ph output used for PWM dimming.
module disp_timebase
    import tamagotchi_disp_pkg::*;
#(
    parameter int DRIVE_CYC = 50000,
    parameter int DEAD_CYC  = 500,
    parameter int CW        = 17
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DISPLAY_SCAN_DIM_EN
    output logic [2:0]  sub_ph,
`endif
    output scan_state_e state_nxt,
    output logic [2:0]  idx_nxt,
    output logic        frame_latch,
    output logic        frame_start
);

    scan_state_e   state;
    logic [2:0]    idx;
    logic [CW-1:0] cyc;
    logic [CW-1:0] cyc_nxt;

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cyc_nxt     = cyc + 1'b1;
        frame_latch = 1'b0;
        case (state)
            DEAD: begin
                if (cyc == CW'(DEAD_CYC - 1)) begin
                    state_nxt   = DRIVE;
                    cyc_nxt     = '0;
                    frame_latch = (idx == 3'd0);
                end
            end
            DRIVE: begin
                if (cyc == CW'(DRIVE_CYC - 1)) begin
                    state_nxt = DEAD;
                    cyc_nxt   = '0;
                    idx_nxt   = (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
                end
            end
            default: begin
                state_nxt = DEAD;
                cyc_nxt   = '0;
            end
        endcase
    end

`ifdef DISPLAY_SCAN_DIM_EN
    assign sub_ph = cyc_nxt[7:5];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= DEAD;
            idx         <= 3'd0;
            cyc         <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cyc         <= cyc_nxt;
            frame_start <= frame_latch;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit multiplexed status display scheduler: per-frame stat snapshot, low-stat
// alert blinking and focus-page arbitration. Optional DISPLAY_SCAN_DIM_EN adds bright[2:0].
module display_scan_ctrl
    import tamagotchi_disp_pkg::*;
#(
    parameter int DRIVE_CYC    = 50000,
    parameter int DEAD_CYC     = 500,
    parameter int BLINK_FRAMES = 64,
    parameter int ALERT_LVL    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] stat_bus,
    input  logic        btn_pulse,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [2:0]  bright,
`endif
    output logic [3:0]  digit_val,
    output logic [2:0]  an,
    output logic [2:0]  an1,
    output logic        frame_start,
    output logic        alert,
    output logic [2:0]  page
);

    localparam int MAXC = (DRIVE_CYC > DEAD_CYC) ? DRIVE_CYC : DEAD_CYC;
    // At least 8 bits so cyc[7:5] exists for the dimming comparison.
    localparam int CW   = ($clog2(MAXC) + 1 > 8) ? $clog2(MAXC) + 1 : 8;
    localparam int FW   = $clog2(BLINK_FRAMES) + 1;

    scan_state_e state_nxt;
    logic [2:0]  idx_nxt;
    logic        frame_latch;
`ifdef DISPLAY_SCAN_DIM_EN
    logic [2:0]  sub_ph;
`endif

    disp_timebase #(
        .DRIVE_CYC (DRIVE_CYC),
        .DEAD_CYC  (DEAD_CYC),
        .CW        (CW)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
`ifdef DISPLAY_SCAN_DIM_EN
        .sub_ph      (sub_ph),
`endif
        .state_nxt   (state_nxt),
        .idx_nxt     (idx_nxt),
        .frame_latch (frame_latch),
        .frame_start (frame_start)
    );

    logic [17:0]   snap, snap_nxt;
    logic [5:0]    flags, flags_nxt;
    logic          blink_ph, blink_ph_nxt;
    logic [FW-1:0] frame_cnt, frame_cnt_nxt;
    logic          seen, seen_nxt;
    logic [2:0]    pend, pend_nxt;
    logic [2:0]    page_nxt;
    logic [2:0]    sel;
    logic          drive_on;
    logic [3:0]    digit_d;
    logic [2:0]    an_d, an1_d;

    always_comb begin
        snap_nxt      = snap;
        flags_nxt     = flags;
        blink_ph_nxt  = blink_ph;
        frame_cnt_nxt = frame_cnt;
        seen_nxt      = seen;
        page_nxt      = page;
        pend_nxt      = pend;
        if (btn_pulse)
            pend_nxt = (pend == 3'd6) ? 3'd0 : pend + 3'd1;

        // Pending page is sampled before this cycle's button press is counted.
        if (frame_latch) begin
            snap_nxt = stat_bus;
            page_nxt = pend;
            for (int i = 0; i < NUM_DIGITS; i++)
                flags_nxt[i] = (32'(stat_at(stat_bus, 3'(i))) <= 32'(ALERT_LVL));
            frame_cnt_nxt = (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
            seen_nxt      = 1'b1;
            if (seen && frame_cnt == '0)
                blink_ph_nxt = ~blink_ph;
        end

        sel      = (page_nxt == 3'd0) ? idx_nxt : page_nxt - 3'd1;
        drive_on = 1'b1;
`ifdef DISPLAY_SCAN_DIM_EN
        drive_on = (sub_ph < bright);
`endif
        digit_d = BLANK_CODE;
        an_d    = 3'b111;
        an1_d   = 3'b111;
        if (state_nxt == DRIVE) begin
            digit_d = (blink_ph_nxt && flags_nxt[sel]) ? BLANK_CODE : {1'b0, stat_at(snap_nxt, sel)};
            if (drive_on) begin
                if (idx_nxt < 3'd3)
                    an_d[idx_nxt[1:0]] = 1'b0;
                else
                    an1_d[2'(idx_nxt - 3'd3)] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap      <= '0;
            flags     <= '0;
            blink_ph  <= 1'b0;
            frame_cnt <= '0;
            seen      <= 1'b0;
            pend      <= 3'd0;
            page      <= 3'd0;
            digit_val <= BLANK_CODE;
            an        <= 3'b111;
            an1       <= 3'b111;
            alert     <= 1'b0;
        end else begin
            snap      <= snap_nxt;
            flags     <= flags_nxt;
            blink_ph  <= blink_ph_nxt;
            frame_cnt <= frame_cnt_nxt;
            seen      <= seen_nxt;
            pend      <= pend_nxt;
            page      <= page_nxt;
            digit_val <= digit_d;
            an        <= an_d;
            an1       <= an1_d;
            alert     <= |flags_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: an arithmetic frame/slot model predicts every drive
// cycle into a queue; a monitor pops and checks whenever an anode is driven.
module tb_display_scan_ctrl;

    localparam int DR = 4;
    localparam int DE = 2;
    localparam int BF = 2;
    localparam int AL = 1;
    localparam int S  = DR + DE;
    localparam int P  = 6 * S;
    localparam int W  = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] stat_bus = 18'o543210;
    logic        btn_pulse = 1'b0;
    logic [3:0]  digit_val;
    logic [2:0]  an, an1, page;
    logic        frame_start, alert;
`ifdef DISPLAY_SCAN_DIM_EN
    logic [2:0]  bright = 3'd7;
`endif

    display_scan_ctrl #(
        .DRIVE_CYC    (DR),
        .DEAD_CYC     (DE),
        .BLINK_FRAMES (BF),
        .ALERT_LVL    (AL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stat_bus    (stat_bus),
        .btn_pulse   (btn_pulse),
`ifdef DISPLAY_SCAN_DIM_EN
        .bright      (bright),
`endif
        .digit_val   (digit_val),
        .an          (an),
        .an1         (an1),
        .frame_start (frame_start),
        .alert       (alert),
        .page        (page)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    int          e = 0;
    logic [17:0] m_snap = '0;
    int          m_page = 0, m_pend = 0, m_ph = 0, m_al = 0;

    function automatic int stat_of(input logic [17:0] b, input int k);
        logic [17:0] sh;
        sh = (b >> (3 * k)) & 18'h7;
        return int'(sh);
    endfunction

    initial begin
        int o, n, w, s, sel, v, dv;
        logic [2:0] a0, a1;
        forever begin
            @(posedge clk);
            if (!rst) begin
                e = 0; m_pend = 0; m_page = 0; m_ph = 0; m_al = 0; m_snap = '0;
                exp_q.delete();
            end else begin
                e++;
                if (e >= DE) begin
                    o = e - DE;
                    n = o / P;
                    w = o % P;
                    s = w / S;
                    if (w == 0) begin
                        m_snap = stat_bus;
                        m_page = m_pend;
                        m_ph   = (n / BF) % 2;
                        m_al   = 0;
                        for (int k = 0; k < 6; k++)
                            if (stat_of(stat_bus, k) <= AL) m_al = 1;
                    end
                    if (w % S < DR) begin
                        sel = (m_page == 0) ? s : m_page - 1;
                        v   = stat_of(m_snap, sel);
                        dv  = (m_ph == 1 && v <= AL) ? 15 : v;
                        a0  = 3'b111;
                        a1  = 3'b111;
                        if (s < 3) a0[s] = 1'b0;
                        else       a1[s - 3] = 1'b0;
                        exp_q.push_back({16'(e), a0, a1, 4'(dv), 3'(m_page), 1'(m_al), 1'(w == 0)});
                    end
                end
                if (btn_pulse) m_pend = (m_pend + 1) % 7;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [14:0]  got;
        logic [W-1:0] ent;
        forever begin
            @(negedge clk);
            if (rst && e > 0) begin
                got = {an, an1, digit_val, page, alert, frame_start};
                total++;
                if (an != 3'b111 || an1 != 3'b111) begin
                    if (exp_q.size() == 0 || exp_q[0][30:15] != 16'(e)) begin
                        bad++;
                        $display("FAIL unexpected_drive cyc=%0d got=%h required=no drive", e, got);
                    end else begin
                        ent = exp_q.pop_front();
                        if (got !== ent[14:0]) begin
                            bad++;
                            $display("FAIL slot cyc=%0d got=%h required=%h", e, got, ent[14:0]);
                        end
                    end
                end else begin
                    if (exp_q.size() != 0 && exp_q[0][30:15] == 16'(e)) begin
                        ent = exp_q.pop_front();
                        bad++;
                        $display("FAIL missing_drive cyc=%0d got=%h required=%h", e, got, ent[14:0]);
                    end else if (digit_val !== 4'hF || frame_start !== 1'b0) begin
                        bad++;
                        $display("FAIL dead cyc=%0d digit_val=%h frame_start=%b required F/0", e, digit_val, frame_start);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return at a negedge inside the DRIVE window of slot k.
    task automatic wait_slot(input int k);
        int budget;
        budget = 2 * P + 4;
        while (!(e >= DE && ((e - DE) % P) / S == k && ((e - DE) % S) < DR) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            total++;
            bad++;
            $display("FAIL wait_slot%0d timeout got=none required=drive", k);
        end
    endtask

    task automatic pulse_btn();
        btn_pulse = 1'b1;
        @(negedge clk);
        btn_pulse = 1'b0;
    endtask

    task automatic check_reset(input string name);
        total++;
        if ({an, an1, digit_val, frame_start, alert, page} !== {3'b111, 3'b111, 4'hF, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL %s an=%b an1=%b dv=%h fs=%b alert=%b page=%0d required 111/111/F/0/0/0",
                     name, an, an1, digit_val, frame_start, alert, page);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        wait_cycles(3);
        check_reset("reset_init");
        rst = 1'b1;
        wait_cycles(2 * P);

        // Mid-frame stat change must not show until the next frame.
        wait_slot(2);
        stat_bus = 18'o777777;
        wait_cycles(2 * P);

        // Health at zero: alert and blink on digit 4.
        stat_bus = 18'o505555;
        wait_cycles(8 * P);

        // Focus page, then wrap back to scan.
        stat_bus = 18'o234563;
        wait_slot(1);
        pulse_btn();
        wait_cycles(2 * P);
        for (int i = 0; i < 6; i++) begin
            pulse_btn();
            wait_cycles($urandom_range(1, 20));
        end
        wait_cycles(2 * P);

        // Reset in the middle of digit 3.
        wait_slot(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset_mid_drive");
        rst = 1'b1;
        wait_cycles(2 * P);

        // Random stats and button presses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) stat_bus = 18'($urandom);
            btn_pulse = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end
        btn_pulse = 1'b0;
        wait_cycles(2 * P);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
